complement_pipe: RTL and testbench

//  Pipelined, multi-lane signed-format converter for the FloatAdder datapath and its successors.

---
 rtl/complement_pipe_pkg.sv | 14 +
 rtl/complement_pipe_lane.sv | 65 ++++++
 rtl/complement_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_complement_pipe.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/complement_pipe_pkg.sv
// Shared definitions for the complement_pipe signed-format converter.
// Mode encodings are shared by the top level, the lane logic and any consumers.
package complement_pipe_pkg;

    localparam int ModeW = 2;

    typedef enum logic [ModeW-1:0] {
        CPL_SM2TC = 2'd0,
        CPL_TC2SM = 2'd1,
        CPL_NEG   = 2'd2,
        CPL_ABS   = 2'd3
    } cpl_mode_e;

endpackage

// File: rtl/complement_pipe_lane.sv
// Per-lane combinational decode: picks the operand, decides whether to complement,
// and produces the low-half sum plus the carry into the upper half.
module complement_lane
    import complement_pipe_pkg::*;
#(
    parameter int Width = 26,
    parameter int LoW   = 13
) (
    input  logic [Width-1:0]     x,
    input  cpl_mode_e            mode,
    input  logic                 en,
    output logic [Width-LoW-1:0] hi_base,
    output logic [LoW-1:0]       lo_sum,
    output logic                 lo_carry,
    output logic                 set_msb,
    output logic                 sat,
    output logic                 ovf
);
    localparam int              LoW1   = LoW + 1;
    localparam logic [Width-1:0] MinVal = {1'b1, {(Width-1){1'b0}}};

    logic             sign;
    logic             is_min;
    logic             cpl;
    logic [Width-1:0] operand;
    logic [Width-1:0] base;

    always_comb begin
        sign    = x[Width-1];
        is_min  = (x == MinVal);
        operand = x;
        cpl     = 1'b0;
        set_msb = 1'b0;
        sat     = 1'b0;
        ovf     = 1'b0;
        if (en) begin
            case (mode)
                CPL_SM2TC: begin
                    operand = {1'b0, x[Width-2:0]};
                    cpl     = sign;
                end
                // Magnitude of a negative word is positive, so the sign bit is forced afterwards.
                CPL_TC2SM: begin
                    cpl     = sign;
                    set_msb = sign;
                    sat     = is_min;
                    ovf     = is_min;
                end
                CPL_NEG: begin
                    cpl = 1'b1;
                    ovf = is_min;
                end
                CPL_ABS: begin
                    cpl = sign;
                    ovf = is_min;
                end
                default: ;
            endcase
        end
        base                = cpl ? ~operand : operand;
        {lo_carry, lo_sum}  = {1'b0, base[LoW-1:0]} + LoW1'(cpl);
        hi_base             = base[Width-1:LoW];
    end

endmodule

// File: rtl/complement_pipe.sv
// Multi-lane pipelined signed-format converter (SM<->2C, negate, abs) with
// valid/ready on both sides and an optional split-carry second stage.
module complement_pipe
    import complement_pipe_pkg::*;
#(
    parameter int Width  = 26,
    parameter int Lanes  = 1,
    parameter int Stages = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [Lanes*Width-1:0] in_data,
    input  logic [1:0]             in_mode,
    input  logic [Lanes-1:0]       in_lane_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [Lanes*Width-1:0] out_data,
    output logic [Lanes-1:0]       out_ovf
);
    localparam int LoW = Width / 2;
    localparam int HiW = Width - LoW;

    if (Stages != 1 && Stages != 2) begin : g_bad_stages
        $error("complement_pipe: Stages must be 1 or 2");
    end
    if (Width < 4 || Width > 64) begin : g_bad_width
        $error("complement_pipe: Width must be 4..64");
    end
    if (Lanes < 1 || Lanes > 8) begin : g_bad_lanes
        $error("complement_pipe: Lanes must be 1..8");
    end

    // Handshake: a beat moves on a rising edge where valid and ready are both 1.
    // Each stage loads only when it is empty or its contents leave on the same edge.

    logic [Lanes-1:0][HiW-1:0] hi_base;
    logic [Lanes-1:0][LoW-1:0] lo_sum;
    logic [Lanes-1:0]          lo_carry;
    logic [Lanes-1:0]          set_msb;
    logic [Lanes-1:0]          sat;
    logic [Lanes-1:0]          ovf;

    for (genvar k = 0; k < Lanes; k++) begin : g_lane
        complement_lane #(
            .Width (Width),
            .LoW   (LoW)
        ) u_lane (
            .x        (in_data[k*Width +: Width]),
            .mode     (cpl_mode_e'(in_mode)),
            .en       (in_lane_en[k]),
            .hi_base  (hi_base[k]),
            .lo_sum   (lo_sum[k]),
            .lo_carry (lo_carry[k]),
            .set_msb  (set_msb[k]),
            .sat      (sat[k]),
            .ovf      (ovf[k])
        );
    end

    function automatic logic [Width-1:0] finish_word(
        input logic [HiW-1:0] hi,
        input logic [LoW-1:0] lo,
        input logic           c,
        input logic           msb,
        input logic           sat_w
    );
        logic [Width-1:0] w;
        w = {hi + HiW'(c), lo};
        if (sat_w) begin
            w = '1;
        end else if (msb) begin
            w[Width-1] = 1'b1;
        end
        return w;
    endfunction

    // in_ready stays low until the first edge after reset release.
    logic alive_q;
    logic alive_d;
    assign alive_d = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alive_q <= 1'b0;
        else        alive_q <= alive_d;
    end

    if (Stages == 1) begin : g_one
        logic                   s1_valid_q, s1_valid_d;
        logic [Lanes*Width-1:0] s1_data_q, s1_data_d;
        logic [Lanes-1:0]       s1_ovf_q, s1_ovf_d;
        logic [Lanes*Width-1:0] word_now;
        logic                   take;

        always_comb begin
            for (int k = 0; k < Lanes; k++) begin
                word_now[k*Width +: Width] =
                    finish_word(hi_base[k], lo_sum[k], lo_carry[k], set_msb[k], sat[k]);
            end
            take       = alive_q & (!s1_valid_q | out_ready);
            s1_valid_d = s1_valid_q;
            s1_data_d  = s1_data_q;
            s1_ovf_d   = s1_ovf_q;
            if (take) begin
                s1_valid_d = in_valid;
                if (in_valid) begin
                    s1_data_d = word_now;
                    s1_ovf_d  = ovf;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid_q <= 1'b0;
                s1_data_q  <= '0;
                s1_ovf_q   <= '0;
            end else begin
                s1_valid_q <= s1_valid_d;
                s1_data_q  <= s1_data_d;
                s1_ovf_q   <= s1_ovf_d;
            end
        end

        assign in_ready  = take;
        assign out_valid = s1_valid_q;
        assign out_data  = s1_data_q;
        assign out_ovf   = s1_ovf_q;
    end else begin : g_two
        logic                      s1_valid_q, s1_valid_d;
        logic [Lanes-1:0][HiW-1:0] s1_hi_q, s1_hi_d;
        logic [Lanes-1:0][LoW-1:0] s1_lo_q, s1_lo_d;
        logic [Lanes-1:0]          s1_c_q, s1_c_d;
        logic [Lanes-1:0]          s1_msb_q, s1_msb_d;
        logic [Lanes-1:0]          s1_sat_q, s1_sat_d;
        logic [Lanes-1:0]          s1_ovf_q, s1_ovf_d;
        logic                      s2_valid_q, s2_valid_d;
        logic [Lanes*Width-1:0]    s2_data_q, s2_data_d;
        logic [Lanes-1:0]          s2_ovf_q, s2_ovf_d;
        logic                      s1_take;
        logic                      s2_take;

        always_comb begin
            s2_take    = !s2_valid_q | out_ready;
            s1_take    = alive_q & (!s1_valid_q | s2_take);
            s1_valid_d = s1_valid_q;
            s1_hi_d    = s1_hi_q;
            s1_lo_d    = s1_lo_q;
            s1_c_d     = s1_c_q;
            s1_msb_d   = s1_msb_q;
            s1_sat_d   = s1_sat_q;
            s1_ovf_d   = s1_ovf_q;
            s2_valid_d = s2_valid_q;
            s2_data_d  = s2_data_q;
            s2_ovf_d   = s2_ovf_q;
            // Upper-half carry add happens here, one register after the low-half add.
            if (s2_take) begin
                s2_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    for (int k = 0; k < Lanes; k++) begin
                        s2_data_d[k*Width +: Width] =
                            finish_word(s1_hi_q[k], s1_lo_q[k], s1_c_q[k], s1_msb_q[k], s1_sat_q[k]);
                    end
                    s2_ovf_d = s1_ovf_q;
                end
            end
            if (s1_take) begin
                s1_valid_d = in_valid;
                if (in_valid) begin
                    s1_hi_d  = hi_base;
                    s1_lo_d  = lo_sum;
                    s1_c_d   = lo_carry;
                    s1_msb_d = set_msb;
                    s1_sat_d = sat;
                    s1_ovf_d = ovf;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid_q <= 1'b0;
                s1_hi_q    <= '0;
                s1_lo_q    <= '0;
                s1_c_q     <= '0;
                s1_msb_q   <= '0;
                s1_sat_q   <= '0;
                s1_ovf_q   <= '0;
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
                s2_ovf_q   <= '0;
            end else begin
                s1_valid_q <= s1_valid_d;
                s1_hi_q    <= s1_hi_d;
                s1_lo_q    <= s1_lo_d;
                s1_c_q     <= s1_c_d;
                s1_msb_q   <= s1_msb_d;
                s1_sat_q   <= s1_sat_d;
                s1_ovf_q   <= s1_ovf_d;
                s2_valid_q <= s2_valid_d;
                s2_data_q  <= s2_data_d;
                s2_ovf_q   <= s2_ovf_d;
            end
        end

        assign in_ready  = s1_take;
        assign out_valid = s2_valid_q;
        assign out_data  = s2_data_q;
        assign out_ovf   = s2_ovf_q;
    end

endmodule

// File: tb/tb_complement_pipe.sv
// Scoreboard bench for complement_pipe: an 8-bit two-lane single-stage instance
// and a 26-bit one-lane two-stage instance share clock and reset.
module tb_complement_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // ---------------- instance a: Width=8, Lanes=2, Stages=1
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [15:0] a_in_data, a_out_data;
    logic [1:0]  a_in_mode, a_in_lane_en, a_out_ovf;

    complement_pipe #(.Width(8), .Lanes(2), .Stages(1)) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .in_data    (a_in_data),
        .in_mode    (a_in_mode),
        .in_lane_en (a_in_lane_en),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .out_data   (a_out_data),
        .out_ovf    (a_out_ovf)
    );

    // ---------------- instance b: Width=26, Lanes=1, Stages=2
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [25:0] b_in_data, b_out_data;
    logic [1:0]  b_in_mode;
    logic        b_in_lane_en, b_out_ovf;

    complement_pipe #(.Width(26), .Lanes(1), .Stages(2)) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_data    (b_in_data),
        .in_mode    (b_in_mode),
        .in_lane_en (b_in_lane_en),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_data   (b_out_data),
        .out_ovf    (b_out_ovf)
    );

    localparam logic [1:0] SM2TC = 2'd0, TC2SM = 2'd1, NEG = 2'd2, ABS = 2'd3;

    // Expected words are {ovf, data}; issue queues hold the transfer cycle, or -1 for no latency check.
    logic [17:0] a_exp_q[$];
    int          a_t_q[$];
    logic [26:0] b_exp_q[$];
    int          b_t_q[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Independent integer model of one 8-bit lane; returns {ovf, word}.
    function automatic logic [8:0] ref8(input logic [7:0] x, input logic [1:0] m, input logic en);
        int v;
        int mag;
        v   = $signed(x);
        mag = x[6:0];
        if (!en) return {1'b0, x};
        case (m)
            SM2TC: return {1'b0, 8'(x[7] ? -mag : mag)};
            TC2SM: begin
                if (x == 8'h80) return {1'b1, 8'hFF};
                if (v < 0)      return {1'b0, 8'(8'h80 | (-v))};
                return {1'b0, x};
            end
            NEG:     return {x == 8'h80, 8'(-v)};
            default: return {x == 8'h80, 8'(v < 0 ? -v : v)};
        endcase
    endfunction

    // ---------------- drivers
    task automatic send_a(input logic [15:0] d, input logic [1:0] m, input logic [1:0] en,
                          input logic [17:0] exp, input bit lat);
        int n;
        n = 0;
        a_in_valid = 1'b1; a_in_data = d; a_in_mode = m; a_in_lane_en = en;
        @(negedge clk);
        while (!a_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL a_in_ready_timeout got=0 exp=1");
            a_in_valid = 1'b0;
            return;
        end
        if (lat) chk("a_throughput_wait", 64'(n), 64'd0);
        @(posedge clk); #1;
        a_exp_q.push_back(exp);
        a_t_q.push_back(lat ? cyc : -1);
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [25:0] d, input logic [1:0] m, input logic [26:0] exp,
                          input bit lat);
        int n;
        n = 0;
        b_in_valid = 1'b1; b_in_data = d; b_in_mode = m; b_in_lane_en = 1'b1;
        @(negedge clk);
        while (!b_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL b_in_ready_timeout got=0 exp=1");
            b_in_valid = 1'b0;
            return;
        end
        if (lat) chk("b_throughput_wait", 64'(n), 64'd0);
        @(posedge clk); #1;
        b_exp_q.push_back(exp);
        b_t_q.push_back(lat ? cyc : -1);
        b_in_valid = 1'b0;
    endtask

    // ---------------- random backpressure for instance a
    bit rand_rdy_a = 1'b0;
    always @(posedge clk) begin
        if (rand_rdy_a) begin
            #1 a_out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- monitors
    logic [17:0] a_e, a_held;
    int          a_t;
    bit          a_held_v = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            a_held_v = 1'b0;
        end else begin
            if (a_out_valid && a_out_ready) begin
                if (a_exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_unexpected_beat got=%h exp=none", {a_out_ovf, a_out_data});
                end else begin
                    a_e = a_exp_q.pop_front();
                    a_t = a_t_q.pop_front();
                    chk("a_beat", 64'({a_out_ovf, a_out_data}), 64'(a_e));
                    if (a_t >= 0) chk("a_latency", 64'(cyc - a_t + 1), 64'd1);
                end
            end
            if (a_out_valid && !a_out_ready) begin
                if (a_held_v) chk("a_stall_stable", 64'({a_out_ovf, a_out_data}), 64'(a_held));
                a_held   = {a_out_ovf, a_out_data};
                a_held_v = 1'b1;
            end else begin
                if (a_held_v) chk("a_valid_held", 64'(a_out_valid), 64'd1);
                a_held_v = 1'b0;
            end
        end
    end

    logic [26:0] b_e, b_held;
    int          b_t;
    bit          b_held_v = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            b_held_v = 1'b0;
        end else begin
            if (b_out_valid && b_out_ready) begin
                if (b_exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected_beat got=%h exp=none", {b_out_ovf, b_out_data});
                end else begin
                    b_e = b_exp_q.pop_front();
                    b_t = b_t_q.pop_front();
                    chk("b_beat", 64'({b_out_ovf, b_out_data}), 64'(b_e));
                    if (b_t >= 0) chk("b_latency", 64'(cyc - b_t + 1), 64'd2);
                end
            end
            if (b_out_valid && !b_out_ready) begin
                if (b_held_v) chk("b_stall_stable", 64'({b_out_ovf, b_out_data}), 64'(b_held));
                b_held   = {b_out_ovf, b_out_data};
                b_held_v = 1'b1;
            end else begin
                if (b_held_v) chk("b_valid_held", 64'(b_out_valid), 64'd1);
                b_held_v = 1'b0;
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((a_exp_q.size() != 0 || b_exp_q.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("a_queue_drained", 64'(a_exp_q.size()), 64'd0);
        chk("b_queue_drained", 64'(b_exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence
    initial begin
        a_in_valid = 1'b0; a_in_data = '0; a_in_mode = '0; a_in_lane_en = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_mode = '0; b_in_lane_en = 1'b0; b_out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("a_reset_valid", 64'(a_out_valid), 64'd0);
        chk("a_reset_data",  64'(a_out_data),  64'd0);
        chk("a_reset_ovf",   64'(a_out_ovf),   64'd0);
        chk("b_reset_valid", 64'(b_out_valid), 64'd0);
        chk("b_reset_data",  64'(b_out_data),  64'd0);
        chk("b_reset_ovf",   64'(b_out_ovf),   64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("a_ready_after_release", 64'(a_in_ready), 64'd1);
        chk("b_ready_after_release", 64'(b_in_ready), 64'd1);

        // Directed, back-to-back, with per-beat mode changes.
        send_a(16'h8580, SM2TC, 2'b11, {2'b00, 16'hFB00}, 1);
        send_a(16'hFB80, TC2SM, 2'b11, {2'b01, 16'h85FF}, 1);
        send_a(16'h0180, NEG,   2'b11, {2'b01, 16'hFF80}, 1);
        send_a(16'hF67F, ABS,   2'b11, {2'b00, 16'h0A7F}, 1);
        send_a(16'h0505, NEG,   2'b01, {2'b00, 16'h05FB}, 1);
        send_a(16'h007F, SM2TC, 2'b11, {2'b00, 16'h007F}, 1);
        send_a(16'h7F01, TC2SM, 2'b11, {2'b00, 16'h7F01}, 1);
        send_a(16'h8000, NEG,   2'b10, {2'b10, 16'h8000}, 1);
        send_a(16'h80FF, ABS,   2'b11, {2'b10, 16'h8001}, 1);
        send_a(16'hFF01, SM2TC, 2'b11, {2'b00, 16'h8101}, 1);
        send_a(16'h8080, TC2SM, 2'b00, {2'b00, 16'h8080}, 1);
        drain();

        // Back-to-back random beats under random backpressure.
        rand_rdy_a = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [15:0] d;
            logic [1:0]  m;
            logic [1:0]  en;
            logic [8:0]  r0, r1;
            d  = 16'($urandom);
            m  = 2'($urandom_range(0, 3));
            en = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            r0 = ref8(d[7:0],  m, en[0]);
            r1 = ref8(d[15:8], m, en[1]);
            send_a(d, m, en, {r1[8], r0[8], r1[7:0], r0[7:0]}, 0);
        end
        rand_rdy_a = 1'b0;
        @(posedge clk); #2;
        a_out_ready = 1'b1;
        drain();

        // Two-stage wide instance, including carries across the low/high split.
        send_b(26'h0000001, NEG,   {1'b0, 26'h3FFFFFF}, 1);
        send_b(26'h0001000, NEG,   {1'b0, 26'h3FFF000}, 1);
        send_b(26'h0002000, NEG,   {1'b0, 26'h3FFE000}, 1);
        send_b(26'h0000000, NEG,   {1'b0, 26'h0000000}, 1);
        send_b(26'h2000000, TC2SM, {1'b1, 26'h3FFFFFF}, 1);
        send_b(26'h3FFE000, ABS,   {1'b0, 26'h0002000}, 1);
        send_b(26'h2000005, SM2TC, {1'b0, 26'h3FFFFFB}, 1);
        send_b(26'h3FFFFFB, TC2SM, {1'b0, 26'h2000005}, 1);
        send_b(26'h2000000, NEG,   {1'b1, 26'h2000000}, 1);
        drain();

        // Reset with beats in flight: nothing stale may appear afterwards.
        a_out_ready = 1'b0;
        b_out_ready = 1'b0;
        send_a(16'h0101, NEG, 2'b11, {2'b00, 16'hFFFF}, 0);
        send_b(26'h0000003, NEG, {1'b0, 26'h3FFFFFD}, 0);
        send_b(26'h0000004, NEG, {1'b0, 26'h3FFFFFC}, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("a_async_reset_valid", 64'(a_out_valid), 64'd0);
        chk("a_async_reset_data",  64'(a_out_data),  64'd0);
        chk("b_async_reset_valid", 64'(b_out_valid), 64'd0);
        chk("b_async_reset_data",  64'(b_out_data),  64'd0);
        a_exp_q.delete(); a_t_q.delete();
        b_exp_q.delete(); b_t_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send_a(16'hFB05, TC2SM, 2'b11, {2'b00, 16'h8505}, 0);
        send_b(26'h0000010, ABS, {1'b0, 26'h0000010}, 0);
        send_b(26'h3FFFFF0, ABS, {1'b0, 26'h0000010}, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net in case a driver loop never returns.
    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
